// File: rtl/range_monitor.sv
// -----------------------------------------------------------------------------
// range_monitor
//
// Watches NCH unsigned sample channels and flags any sample outside the
// inclusive window [LO, HI]. Monitoring is started with arm, which also
// starts a HOLDOFF-cycle blind period. The first checked violation while
// ARMED trips the monitor and captures the lowest-indexed offending channel
// and its value. Sticky flags and saturating counters keep updating while
// TRIPPED. All outputs are registered, so a checked sample shows up on the
// outputs one cycle after its sampling edge.
//
// Input qualifier: in_data is only looked at on a rising edge where
// in_valid=1 and the check is active (not DISARMED, holdoff expired). There
// is no back-pressure; samples that arrive while inactive are dropped.
//
// Command priority on any edge: disarm > clear > arm > sample check. A
// sample that coincides with disarm or clear is discarded.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   reset       : asynchronous active-high reset
//   arm         : start monitoring (only acts in DISARMED)
//   disarm      : stop monitoring, keeps sticky/count/trip data
//   clear       : zero sticky/count/trip data, TRIPPED -> ARMED
//   in_valid    : in_data qualifier
//   in_data     : NCH packed samples, channel i at [i*WIDTH +: WIDTH]
//   state       : 0=DISARMED, 1=ARMED, 2=TRIPPED (also the FSM debug view)
//   viol_any    : 1-cycle pulse after a checked sample with a violation
//   viol_sticky : per-channel sticky violation flags
//   viol_count  : per-channel saturating violation counters
//   trip_chan   : channel that caused the trip
//   trip_value  : sample value that caused the trip
// -----------------------------------------------------------------------------
module range_monitor #(
    parameter int WIDTH   = 4,
    parameter int NCH     = 4,
    parameter int LO      = 4,
    parameter int HI      = 11,
    parameter int HOLDOFF = 2,
    parameter int CNT_W   = 4,
    localparam int TC_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [1:0]             state,
    output logic                   viol_any,
    output logic [NCH-1:0]         viol_sticky,
    output logic [NCH*CNT_W-1:0]   viol_count,
    output logic [TC_W-1:0]        trip_chan,
    output logic [WIDTH-1:0]       trip_value
);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_TRIPPED  = 2'd2
    } state_t;

    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF);
    localparam logic [WIDTH-1:0] LO_V    = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V    = WIDTH'(HI);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [HO_W-1:0]  holdoff_q;

    logic             check_fire;
    logic [NCH-1:0]   viol;
    logic             any_viol;
    logic [TC_W-1:0]  first_idx;
    logic [WIDTH-1:0] first_val;

    assign state = state_q;

    // A sample is evaluated only when monitoring and past the blind period.
    assign check_fire = in_valid && (state_q != S_DISARMED) && (holdoff_q == '0);

    // Per-channel window test and lowest-index violator selection. Scanning
    // from the top down lets the lowest violating index win.
    always_comb begin
        viol      = '0;
        first_idx = '0;
        first_val = '0;
        for (int i = 0; i < NCH; i++) begin
            viol[i] = (in_data[i*WIDTH +: WIDTH] < LO_V) ||
                      (in_data[i*WIDTH +: WIDTH] > HI_V);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (viol[i]) begin
                first_idx = TC_W'(i);
                first_val = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_viol = |viol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_DISARMED;
            holdoff_q   <= '0;
            viol_any    <= 1'b0;
            viol_sticky <= '0;
            viol_count  <= '0;
            trip_chan   <= '0;
            trip_value  <= '0;
        end else begin
            viol_any <= 1'b0;

            // Holdoff runs down regardless of traffic; command branches
            // below may override it.
            if (holdoff_q != '0) begin
                holdoff_q <= holdoff_q - HO_W'(1);
            end

            if (disarm) begin
                state_q   <= S_DISARMED;
                holdoff_q <= '0;
            end else if (clear) begin
                viol_sticky <= '0;
                viol_count  <= '0;
                trip_chan   <= '0;
                trip_value  <= '0;
                if (state_q == S_TRIPPED) begin
                    state_q   <= S_ARMED;
                    holdoff_q <= '0;
                end
            end else if (arm && (state_q == S_DISARMED)) begin
                state_q   <= S_ARMED;
                holdoff_q <= HO_LOAD;
            end else if (check_fire) begin
                viol_any <= any_viol;
                for (int i = 0; i < NCH; i++) begin
                    if (viol[i]) begin
                        viol_sticky[i] <= 1'b1;
                        if (viol_count[i*CNT_W +: CNT_W] != CNT_MAX) begin
                            viol_count[i*CNT_W +: CNT_W] <=
                                viol_count[i*CNT_W +: CNT_W] + CNT_W'(1);
                        end
                    end
                end
                // Trip data is captured once; TRIPPED only accumulates stats.
                if ((state_q == S_ARMED) && any_viol) begin
                    state_q    <= S_TRIPPED;
                    trip_chan  <= first_idx;
                    trip_value <= first_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_range_monitor.sv
// -----------------------------------------------------------------------------
// tb_range_monitor
//
// Directed bench for range_monitor with default parameters (WIDTH=4, NCH=4,
// LO=4, HI=11, HOLDOFF=2, CNT_W=4). Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, i.e. they show the
// result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_range_monitor;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        disarm;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  state;
    logic        viol_any;
    logic [3:0]  viol_sticky;
    logic [15:0] viol_count;
    logic [1:0]  trip_chan;
    logic [3:0]  trip_value;

    int errors;
    int checks;

    range_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .disarm      (disarm),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .state       (state),
        .viol_any    (viol_any),
        .viol_sticky (viol_sticky),
        .viol_count  (viol_count),
        .trip_chan   (trip_chan),
        .trip_value  (trip_value)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pack4(input logic [3:0] c3, input logic [3:0] c2,
                                          input logic [3:0] c1, input logic [3:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm      = 1'b0;
        disarm   = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = pack4(4'd7, 4'd7, 4'd7, 4'd7);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Arm and wait out the 2-cycle holdoff with no traffic.
    task automatic arm_and_wait();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL reset_viol_any: got %0b expected 0", viol_any); end
        checks++; if (viol_sticky !== 4'h0) begin errors++; $display("FAIL reset_sticky: got %h expected 0", viol_sticky); end
        checks++; if (viol_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", viol_count); end
        checks++; if (trip_chan !== 2'd0) begin errors++; $display("FAIL reset_trip_chan: got %0d expected 0", trip_chan); end
        checks++; if (trip_value !== 4'd0) begin errors++; $display("FAIL reset_trip_value: got %0d expected 0", trip_value); end
    endtask

    task automatic test_in_range();
        do_reset();
        arm = 1'b1;
        step();
        arm = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL inrange_armed: got %0d expected 1", state); end
        in_valid = 1'b1;
        in_data  = pack4(4'd7, 4'd7, 4'd7, 4'd7);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL inrange_state[%0d]: got %0d expected 1", k, state); end
            checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL inrange_viol_any[%0d]: got %0b expected 0", k, viol_any); end
        end
        checks++; if (viol_count !== 16'h0) begin errors++; $display("FAIL inrange_count: got %h expected 0", viol_count); end
        in_valid = 1'b0;
    endtask

    task automatic test_holdoff();
        do_reset();
        arm = 1'b1;
        step();
        arm = 1'b0;
        in_valid = 1'b1;
        in_data  = pack4(4'd7, 4'd12, 4'd7, 4'd7);
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL holdoff_state[%0d]: got %0d expected 1", k, state); end
            checks++; if (viol_count !== 16'h0) begin errors++; $display("FAIL holdoff_count[%0d]: got %h expected 0", k, viol_count); end
            checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL holdoff_viol_any[%0d]: got %0b expected 0", k, viol_any); end
        end
        step();
        in_valid = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL holdoff_trip_state: got %0d expected 2", state); end
        checks++; if (viol_any !== 1'b1) begin errors++; $display("FAIL holdoff_viol_any: got %0b expected 1", viol_any); end
        checks++; if (trip_chan !== 2'd2) begin errors++; $display("FAIL holdoff_trip_chan: got %0d expected 2", trip_chan); end
        checks++; if (trip_value !== 4'd12) begin errors++; $display("FAIL holdoff_trip_value: got %0d expected 12", trip_value); end
        checks++; if (viol_count !== 16'h0100) begin errors++; $display("FAIL holdoff_count2: got %h expected 0100", viol_count); end
        checks++; if (viol_sticky !== 4'b0100) begin errors++; $display("FAIL holdoff_sticky: got %b expected 0100", viol_sticky); end
        step();
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL holdoff_pulse_end: got %0b expected 0", viol_any); end
    endtask

    task automatic test_multi_channel();
        do_reset();
        arm_and_wait();
        in_valid = 1'b1;
        in_data  = pack4(4'd15, 4'd7, 4'd3, 4'd7);
        step();
        in_valid = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL multi_state: got %0d expected 2", state); end
        checks++; if (trip_chan !== 2'd1) begin errors++; $display("FAIL multi_trip_chan: got %0d expected 1", trip_chan); end
        checks++; if (trip_value !== 4'd3) begin errors++; $display("FAIL multi_trip_value: got %0d expected 3", trip_value); end
        checks++; if (viol_sticky !== 4'b1010) begin errors++; $display("FAIL multi_sticky: got %b expected 1010", viol_sticky); end
        checks++; if (viol_count !== 16'h1010) begin errors++; $display("FAIL multi_count: got %h expected 1010", viol_count); end
        checks++; if (viol_any !== 1'b1) begin errors++; $display("FAIL multi_viol_any: got %0b expected 1", viol_any); end
        step();
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL multi_pulse_end: got %0b expected 0", viol_any); end
    endtask

    // Continues from the TRIPPED state left by test_multi_channel.
    task automatic test_saturation();
        logic [3:0] exp_c0;
        in_valid = 1'b1;
        in_data  = pack4(4'd7, 4'd7, 4'd7, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_c0 = (k > 15) ? 4'd15 : 4'(k);
            checks++; if (viol_count[3:0] !== exp_c0) begin errors++; $display("FAIL sat_count0[%0d]: got %0d expected %0d", k, viol_count[3:0], exp_c0); end
        end
        in_valid = 1'b0;
        checks++; if (trip_chan !== 2'd1) begin errors++; $display("FAIL sat_trip_chan: got %0d expected 1", trip_chan); end
        checks++; if (trip_value !== 4'd3) begin errors++; $display("FAIL sat_trip_value: got %0d expected 3", trip_value); end
        checks++; if (viol_sticky !== 4'b1011) begin errors++; $display("FAIL sat_sticky: got %b expected 1011", viol_sticky); end
        checks++; if (viol_count[15:4] !== 12'h101) begin errors++; $display("FAIL sat_other_counts: got %h expected 101", viol_count[15:4]); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL sat_state: got %0d expected 2", state); end
    endtask

    // Continues from TRIPPED.
    task automatic test_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = pack4(4'd7, 4'd7, 4'd7, 4'd0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL clear_state: got %0d expected 1", state); end
        checks++; if (viol_count !== 16'h0) begin errors++; $display("FAIL clear_count: got %h expected 0", viol_count); end
        checks++; if (viol_sticky !== 4'h0) begin errors++; $display("FAIL clear_sticky: got %b expected 0", viol_sticky); end
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL clear_viol_any: got %0b expected 0", viol_any); end
        checks++; if (trip_value !== 4'd0) begin errors++; $display("FAIL clear_trip_value: got %0d expected 0", trip_value); end
        // Holdoff is 0 after clear, so the very next sample is checked.
        in_valid = 1'b1;
        in_data  = pack4(4'd7, 4'd13, 4'd7, 4'd7);
        step();
        in_valid = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL clear_retrip_state: got %0d expected 2", state); end
        checks++; if (trip_chan !== 2'd2) begin errors++; $display("FAIL clear_retrip_chan: got %0d expected 2", trip_chan); end
        checks++; if (trip_value !== 4'd13) begin errors++; $display("FAIL clear_retrip_value: got %0d expected 13", trip_value); end
    endtask

    // Continues from TRIPPED (ch2=13, count2=1, sticky=0100).
    task automatic test_disarm();
        disarm   = 1'b1;
        in_valid = 1'b1;
        in_data  = pack4(4'd7, 4'd7, 4'd7, 4'd1);
        step();
        disarm = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL disarm_state: got %0d expected 0", state); end
        checks++; if (viol_sticky !== 4'b0100) begin errors++; $display("FAIL disarm_sticky: got %b expected 0100", viol_sticky); end
        checks++; if (viol_count !== 16'h0100) begin errors++; $display("FAIL disarm_count: got %h expected 0100", viol_count); end
        checks++; if (trip_value !== 4'd13) begin errors++; $display("FAIL disarm_trip_value: got %0d expected 13", trip_value); end
        // Violating traffic while DISARMED changes nothing.
        step();
        step();
        in_valid = 1'b0;
        checks++; if (viol_count !== 16'h0100) begin errors++; $display("FAIL disarmed_ignore_count: got %h expected 0100", viol_count); end
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL disarmed_ignore_any: got %0b expected 0", viol_any); end
    endtask

    task automatic test_boundary();
        do_reset();
        arm_and_wait();
        in_valid = 1'b1;
        in_data  = pack4(4'd4, 4'd4, 4'd4, 4'd4);
        step();
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL bound_lo_any: got %0b expected 0", viol_any); end
        in_data = pack4(4'd11, 4'd11, 4'd11, 4'd11);
        step();
        checks++; if (viol_any !== 1'b0) begin errors++; $display("FAIL bound_hi_any: got %0b expected 0", viol_any); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL bound_state: got %0d expected 1", state); end
        // arm while ARMED must not restart the holdoff: next sample is checked.
        arm     = 1'b1;
        in_data = pack4(4'd11, 4'd4, 4'd11, 4'd4);
        step();
        arm     = 1'b0;
        in_data = pack4(4'd12, 4'd4, 4'd11, 4'd4);
        step();
        in_valid = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL bound_hi1_state: got %0d expected 2", state); end
        checks++; if (trip_chan !== 2'd3) begin errors++; $display("FAIL bound_hi1_chan: got %0d expected 3", trip_chan); end
        checks++; if (viol_count !== 16'h1000) begin errors++; $display("FAIL bound_hi1_count: got %h expected 1000", viol_count); end
    endtask

    // Continues from TRIPPED; reset asserted between edges.
    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d expected 0", state); end
        checks++; if (viol_count !== 16'h0) begin errors++; $display("FAIL areset_count: got %h expected 0", viol_count); end
        checks++; if (viol_sticky !== 4'h0) begin errors++; $display("FAIL areset_sticky: got %b expected 0", viol_sticky); end
        checks++; if (trip_chan !== 2'd0) begin errors++; $display("FAIL areset_trip_chan: got %0d expected 0", trip_chan); end
        checks++; if (trip_value !== 4'd0) begin errors++; $display("FAIL areset_trip_value: got %0d expected 0", trip_value); end
        step();
        reset = 1'b0;
        // Without a new arm, violating samples are ignored.
        in_valid = 1'b1;
        in_data  = pack4(4'd0, 4'd0, 4'd0, 4'd0);
        step();
        step();
        step();
        in_valid = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL areset_stay_state: got %0d expected 0", state); end
        checks++; if (viol_count !== 16'h0) begin errors++; $display("FAIL areset_stay_count: got %h expected 0", viol_count); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_in_range();
        test_holdoff();
        test_multi_channel();
        test_saturation();
        test_clear();
        test_disarm();
        test_boundary();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/range_monitor.md
RANGE_MONITOR -- requirements
Module: range_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, sample width per channel in bits.
REQ-002 The block SHALL have parameter NCH, default 4, number of monitored channels (1..16).
REQ-003 The block SHALL have parameter LO, default 4, inclusive unsigned lower bound (LO <= HI).
REQ-004 The block SHALL have parameter HI, default 11, inclusive unsigned upper bound.
REQ-005 The block SHALL have parameter HOLDOFF, default 2, cycles ignored after arming (0 allowed).
REQ-006 The block SHALL have parameter CNT_W, default 4, per-channel violation counter width.
REQ-007 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port arm, input, 1, start monitoring pulse.
REQ-010 The block SHALL have port disarm, input, 1, stop monitoring pulse.
REQ-011 The block SHALL have port clear, input, 1, clear sticky, counter and trip state.
REQ-012 The block SHALL have port in_valid, input, 1, in_data qualifier.
REQ-013 The block SHALL have port in_data, input, NCH*WIDTH, channel i at bits [i*WIDTH +: WIDTH].
REQ-014 The block SHALL have port state, output, 2, 0=DISARMED, 1=ARMED, 2=TRIPPED.
REQ-015 The block SHALL have port viol_any, output, 1, one-cycle pulse: last checked sample had any violation.
REQ-016 The block SHALL have port viol_sticky, output, NCH, per-channel sticky violation flags.
REQ-017 The block SHALL have port viol_count, output, NCH*CNT_W, per-channel saturating violation counts.
REQ-018 The block SHALL have port trip_chan, output, clog2(NCH) (min 1), channel that caused the trip.
REQ-019 The block SHALL have port trip_value, output, WIDTH, sample value that caused the trip.

Function
REQ-020 A check SHALL be active when state != DISARMED and the holdoff counter is 0; a sample is checked on a rising edge with in_valid=1 and the check active.
REQ-021 Channel i SHALL violate when unsigned in_data_i < LO or > HI; values equal to LO or HI SHALL pass.
REQ-022 All outputs SHALL be registered; a checked sample SHALL be reflected on the outputs in the cycle after its sampling edge (1-cycle latency).
REQ-023 viol_any SHALL be 1 for exactly the cycle after a checked sample with one or more violating channels, otherwise 0.
REQ-024 A checked violation SHALL set viol_sticky[i] and increment viol_count_i, saturating at 2^CNT_W-1 without wrap.
REQ-025 FSM: DISARMED -arm-> ARMED, loading holdoff counter with HOLDOFF; arm in ARMED or TRIPPED SHALL be ignored.
REQ-026 The holdoff counter SHALL decrement by 1 per cycle while nonzero, independent of in_valid.
REQ-027 FSM: ARMED with a checked violation SHALL go to TRIPPED, capturing the lowest-indexed violating channel into trip_chan and its value into trip_value.
REQ-028 In TRIPPED, sticky flags and counters SHALL keep updating; trip_chan and trip_value SHALL hold.
REQ-029 clear SHALL zero viol_sticky, viol_count, trip_chan and trip_value, and move TRIPPED to ARMED with holdoff 0; in other states, state is unchanged.
REQ-030 disarm SHALL move any state to DISARMED and load holdoff with 0; sticky, counters and trip data SHALL be retained.
REQ-031 Priority SHALL be disarm > clear > arm > sample check; a sample coinciding with disarm or clear SHALL be discarded.
REQ-032 When in_valid=0, or the check is inactive, no flag, counter or state SHALL change because of in_data.

Reset
REQ-033 reset=1 SHALL immediately and asynchronously force state=DISARMED, holdoff=0, viol_any=0, viol_sticky=0, viol_count=0, trip_chan=0 and trip_value=0.
REQ-034 Reset asserted mid-holdoff or in TRIPPED SHALL abandon all activity; after deassertion, arm is required to resume monitoring.

Verification
REQ-035 Reset, then arm, then in_valid with all channels=4'd7 for 5 cycles -> state=1, viol_any=0, all counts 0.
REQ-036 Arm, then in_data ch2=4'd12 on cycles 1-2 (holdoff) and cycle 3 -> only cycle 3 counted; state=2, trip_chan=2, trip_value=12, count2=1.
REQ-037 ARMED, one sample with ch1=3 and ch3=15 -> trip_chan=1, trip_value=3, viol_sticky=4'b1010, viol_any pulses 1 cycle.
REQ-038 TRIPPED, 20 violating samples on ch0 -> count0 saturates at 15; trip data unchanged.
REQ-039 clear with a violating sample on the same edge -> sample discarded, counts=0, sticky=0, state=1.
REQ-040 Boundary values 4 and 11 on all channels -> no violation; reset asserted in TRIPPED -> all outputs 0 asynchronously.
